display_compositor: RTL and testbench

DISPLAY_COMPOSITOR -- requirements
Module: display_compositor

---
 rtl/display_pkg.sv | 24 ++
 rtl/compositor_fade_fsm.sv | 96 +++++++++
 rtl/display_compositor.sv | 102 ++++++++++
 tb/tb_display_compositor.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the display compositor: fade states, colour key, frame-start helpers.
// No logic of its own; imported by display_compositor and compositor_fade_fsm.
package display_pkg;

    typedef enum logic [1:0] {
        NORMAL     = 2'd0,
        FADING_OUT = 2'd1,
        BLANK      = 2'd2,
        FADING_IN  = 2'd3
    } fade_state_t;

    // Magenta is the colour key when transparency keying is built in.
    localparam logic [11:0] TRANSPARENT_KEY = 12'hF0F;

    localparam logic [9:0] FRAME_START_X = 10'd0;
    localparam logic [9:0] FRAME_START_Y = 10'd0;

    function automatic logic is_frame_start(input logic       tick,
                                            input logic [9:0] px,
                                            input logic [9:0] py);
        return tick && (px == FRAME_START_X) && (py == FRAME_START_Y);
    endfunction

endpackage

// File: rtl/compositor_fade_fsm.sv
// Fade controller: owns fade state, fade_shift, frame step counter and fade_busy.
// Latency: requests take effect on the next clk edge; shift steps on frame-start edges.
// Backpressure: none; single-cycle requests are always accepted or ignored.
module compositor_fade_fsm
    import display_pkg::*;
#(
    parameter int CH_W            = 4,
    parameter int FRAMES_PER_STEP = 4,
    parameter int SHIFT_W         = $clog2(CH_W + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               fade_out_req,
    input  logic               fade_in_req,
    output logic [SHIFT_W-1:0] fade_shift,
    output logic               fade_busy
);

    localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(CH_W);
    localparam logic [7:0]         STEP_LAST = 8'(FRAMES_PER_STEP - 1);

    fade_state_t        state, state_nxt;
    logic [SHIFT_W-1:0] shift_nxt;
    logic [7:0]         cnt, cnt_nxt;
    logic               in_req;
    logic               step;

    // fade_out_req wins a simultaneous request, so fade-in only counts alone.
    assign in_req = fade_in_req & ~fade_out_req;
    assign step   = frame_start && (cnt == STEP_LAST);

    always_comb begin
        state_nxt = state;
        shift_nxt = fade_shift;
        cnt_nxt   = cnt;
        case (state)
            NORMAL: begin
                if (fade_out_req) begin
                    state_nxt = FADING_OUT;
                    cnt_nxt   = '0;
                end
            end
            BLANK: begin
                if (in_req) begin
                    state_nxt = FADING_IN;
                    cnt_nxt   = '0;
                end
            end
            FADING_OUT: begin
                if (in_req) begin
                    state_nxt = FADING_IN;
                end else if (frame_start) begin
                    cnt_nxt = step ? 8'd0 : cnt + 8'd1;
                    if (step) begin
                        shift_nxt = fade_shift + SHIFT_W'(1);
                        if (shift_nxt == SHIFT_MAX)
                            state_nxt = BLANK;
                    end
                end
            end
            FADING_IN: begin
                if (fade_out_req) begin
                    state_nxt = FADING_OUT;
                end else if (frame_start) begin
                    cnt_nxt = step ? 8'd0 : cnt + 8'd1;
                    if (step) begin
                        shift_nxt = fade_shift - SHIFT_W'(1);
                        if (shift_nxt == '0)
                            state_nxt = NORMAL;
                    end
                end
            end
            default: begin
                state_nxt = NORMAL;
                shift_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= NORMAL;
            fade_shift <= '0;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            fade_shift <= shift_nxt;
            cnt        <= cnt_nxt;
        end
    end

    assign fade_busy = (state == FADING_OUT) || (state == FADING_IN);

endmodule

// File: rtl/display_compositor.sv
// Layer compositor: priority mux of object layers over background, then per-channel fade shift.
// Latency: 2 pixel_ticks from inputs to rgb; everything holds when pixel_tick is low.
// Backpressure: none. Optional macro DISPLAY_COMPOSITOR_TRANSPARENCY_EN enables colour keying.
module display_compositor
    import display_pkg::*;
#(
    parameter int NUM_LAYERS      = 4,
    parameter int CH_W            = 4,
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic                         clk,
    input  logic                         hard_reset_n,
    input  logic                         pixel_tick,
    input  logic                         video_on,
    input  logic [9:0]                   x,
    input  logic [9:0]                   y,
    input  logic [3*CH_W-1:0]            bg_rgb,
    input  logic [NUM_LAYERS*3*CH_W-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]        layer_on,
    input  logic [NUM_LAYERS-1:0]        layer_en,
    input  logic                         fade_out_req,
    input  logic                         fade_in_req,
    output logic [3*CH_W-1:0]            rgb,
    output logic                         fade_busy,
    output logic [15:0]                  frame_count
);

    localparam int RGB_W   = 3 * CH_W;
    localparam int SHIFT_W = $clog2(CH_W + 1);

    logic                  frame_start;
    logic [NUM_LAYERS-1:0] act_en, eff_en, hit;
    logic [RGB_W-1:0]      sel_rgb, s1_rgb, shifted;
    logic                  s1_vid;
    logic [SHIFT_W-1:0]    fade_shift;

    assign frame_start = is_frame_start(pixel_tick, x, y);

    // The frame-start pixel already belongs to the new frame, so it sees the new enables.
    assign eff_en = frame_start ? layer_en : act_en;

`ifdef DISPLAY_COMPOSITOR_TRANSPARENCY_EN
    localparam logic [RGB_W-1:0] KEY = RGB_W'(TRANSPARENT_KEY);

    always_comb begin
        hit = '0;
        for (int k = 0; k < NUM_LAYERS; k++)
            hit[k] = layer_on[k] & eff_en[k] & (layer_rgb[k*RGB_W +: RGB_W] != KEY);
    end
`else
    assign hit = layer_on & eff_en;
`endif

    // Walk from the highest index down so the lowest hit layer is written last.
    always_comb begin
        sel_rgb = bg_rgb;
        for (int k = NUM_LAYERS - 1; k >= 0; k--)
            if (hit[k])
                sel_rgb = layer_rgb[k*RGB_W +: RGB_W];
    end

    always_comb begin
        shifted = '0;
        for (int c = 0; c < 3; c++)
            shifted[c*CH_W +: CH_W] = s1_rgb[c*CH_W +: CH_W] >> fade_shift;
    end

    always_ff @(posedge clk or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            act_en      <= '1;
            frame_count <= '0;
            s1_rgb      <= '0;
            s1_vid      <= 1'b0;
            rgb         <= '0;
        end else begin
            if (frame_start) begin
                act_en      <= layer_en;
                frame_count <= frame_count + 16'd1;
            end
            if (pixel_tick) begin
                s1_rgb <= sel_rgb;
                s1_vid <= video_on;
                rgb    <= s1_vid ? shifted : '0;
            end
        end
    end

    compositor_fade_fsm #(
        .CH_W            (CH_W),
        .FRAMES_PER_STEP (FRAMES_PER_STEP),
        .SHIFT_W         (SHIFT_W)
    ) u_fade_fsm (
        .clk          (clk),
        .rst_n        (hard_reset_n),
        .frame_start  (frame_start),
        .fade_out_req (fade_out_req),
        .fade_in_req  (fade_in_req),
        .fade_shift   (fade_shift),
        .fade_busy    (fade_busy)
    );

endmodule

// File: tb/tb_display_compositor.sv
// Scoreboard bench for display_compositor on a small 8x4 frame with a 6x3 visible area.
module tb_display_compositor;

    localparam int NL = 4, CW = 4, FPS = 1, RW = 12, FW = 8, FH = 4;
    localparam int S_NORM = 0, S_OUT = 1, S_BLK = 2, S_IN = 3;
    localparam int REQ_OUT = 1, REQ_IN = 2, REQ_BOTH = 3;

    logic           clk = 1'b0;
    logic           hard_reset_n, pixel_tick, video_on, fade_out_req, fade_in_req;
    logic [9:0]     x, y;
    logic [RW-1:0]  bg_rgb, rgb;
    logic [NL*RW-1:0] layer_rgb;
    logic [NL-1:0]  layer_on, layer_en;
    logic           fade_busy;
    logic [15:0]    frame_count;

    always #5 clk = ~clk;

    display_compositor #(.NUM_LAYERS(NL), .CH_W(CW), .FRAMES_PER_STEP(FPS)) dut (
        .clk          (clk),
        .hard_reset_n (hard_reset_n),
        .pixel_tick   (pixel_tick),
        .video_on     (video_on),
        .x            (x),
        .y            (y),
        .bg_rgb       (bg_rgb),
        .layer_rgb    (layer_rgb),
        .layer_on     (layer_on),
        .layer_en     (layer_en),
        .fade_out_req (fade_out_req),
        .fade_in_req  (fade_in_req),
        .rgb          (rgb),
        .fade_busy    (fade_busy),
        .frame_count  (frame_count)
    );

    typedef struct packed {
        logic          vid;
        logic [RW-1:0] col;
    } pix_t;

    pix_t          sb[$];
    logic [NL-1:0] m_act;
    int            m_state, m_shift, m_cnt;
    logic [15:0]   m_fc;
    logic [RW-1:0] last_rgb;
    int            n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = '1; m_state = S_NORM; m_shift = 0; m_cnt = 0; m_fc = '0;
        last_rgb = '0;
        sb.delete();
        sb.push_back('0);   // stage-1 register content right after reset
        x = '0; y = '0; video_on = 1'b1;
    endtask

    function automatic logic [RW-1:0] ref_pick(input logic [NL-1:0] en);
        logic [RW-1:0] c, lc;
        bit found;
        c = bg_rgb; found = 0;
        for (int k = 0; k < NL; k++) begin
            lc = layer_rgb[k*RW +: RW];
`ifdef DISPLAY_COMPOSITOR_TRANSPARENCY_EN
            if (lc == 12'hF0F) continue;
`endif
            if (!found && layer_on[k] && en[k]) begin
                c = lc; found = 1;
            end
        end
        return c;
    endfunction

    function automatic logic [RW-1:0] dim(input logic [RW-1:0] c, input int s);
        logic [RW-1:0] r;
        r = '0;
        for (int k = 0; k < 3; k++)
            r[k*CW +: CW] = CW'(int'(c[k*CW +: CW]) / (1 << s));
        return r;
    endfunction

    task automatic model_fsm(input bit fs);
        bit o, i;
        o = fade_out_req;
        i = fade_in_req && !fade_out_req;
        case (m_state)
            S_NORM: if (o) begin m_state = S_OUT; m_cnt = 0; end
            S_BLK:  if (i) begin m_state = S_IN;  m_cnt = 0; end
            S_OUT:  if (i) m_state = S_IN;
                    else if (fs && ++m_cnt == FPS) begin
                        m_cnt = 0; m_shift++;
                        if (m_shift == CW) m_state = S_BLK;
                    end
            default: if (o) m_state = S_OUT;
                    else if (fs && ++m_cnt == FPS) begin
                        m_cnt = 0; m_shift--;
                        if (m_shift == 0) m_state = S_NORM;
                    end
        endcase
    endtask

    // One clock: push the expected stage-1 entry, advance the model, compare after the edge.
    task automatic cyc(input bit tk);
        bit            fs;
        int            sh_pre;
        pix_t          e;
        logic [RW-1:0] expv;
        pixel_tick = tk;
        fs = tk && x == 0 && y == 0;
        sh_pre = m_shift;
        if (tk) begin
            e.vid = video_on;
            e.col = ref_pick(fs ? layer_en : m_act);
            sb.push_back(e);
        end
        model_fsm(fs);
        if (fs) begin m_act = layer_en; m_fc++; end
        @(posedge clk); #1;
        if (tk) begin
            e = sb.pop_front();
            expv = e.vid ? dim(e.col, sh_pre) : '0;
            check("rgb", rgb, expv);
            last_rgb = expv;
        end else begin
            check("rgb_hold", rgb, last_rgb);
        end
        check("frame_count", frame_count, m_fc);
        check("fade_busy", fade_busy, m_state == S_OUT || m_state == S_IN);
        pixel_tick = 0; fade_out_req = 0; fade_in_req = 0;
        if (tk) begin
            if (x == FW - 1) begin x = '0; y = (y == FH - 1) ? 10'd0 : y + 10'd1; end
            else x = x + 10'd1;
            video_on = (x < 6) && (y < 3);
        end
    endtask

    task automatic run_frame(input int req_at, input int req, input int en_at,
                             input logic [NL-1:0] en_val, input bit rnd,
                             output logic [RW-1:0] smp);
        smp = '0;
        for (int i = 0; i < FW * FH; i++) begin
            if (i == en_at) layer_en = en_val;
            if (rnd) begin
                layer_on  = NL'($urandom);
                layer_rgb = (NL*RW)'({$urandom, $urandom});
                if ($urandom_range(0, 3) == 0) layer_rgb[RW-1:0] = 12'hF0F;
                bg_rgb = RW'($urandom);
            end
            if (i == req_at) begin
                fade_out_req = req[0]; fade_in_req = req[1];
                cyc(0);
            end
            if ($urandom_range(0, 4) == 0) cyc(0);
            cyc(1);
            if (i == 11) smp = rgb;
        end
    endtask

    logic [RW-1:0] s;
    logic [RW-1:0] fade_seq [4];
    logic [RW-1:0] exp_key;

    initial begin
        hard_reset_n = 0; pixel_tick = 0; fade_out_req = 0; fade_in_req = 0;
        bg_rgb = 12'h00F; layer_rgb = '0; layer_on = '0; layer_en = '1;
        model_reset();
        #12;
        check("reset_rgb", rgb, 0);
        check("reset_busy", fade_busy, 0);
        check("reset_frame_count", frame_count, 0);
        @(negedge clk) hard_reset_n = 1;

        // Layers 0 and 2 hit; layer 0 has priority.
        layer_rgb = {12'h333, 12'hF00, 12'h0A0, 12'h0F0};
        layer_on  = 4'b0101;
        run_frame(-1, 0, -1, '0, 0, s);
        check("s038_priority", s, 12'h0F0);

        // Enable drop mid-frame only takes effect at the next frame start.
        run_frame(-1, 0, 4, 4'b1110, 0, s);
        check("s039_held", s, 12'h0F0);
        run_frame(-1, 0, -1, '0, 0, s);
        check("s039_next", s, 12'hF00);

        layer_en = '1;
        for (int f = 0; f < 3; f++) run_frame(-1, 0, 20, NL'($urandom), 1, s);

        // Full fade out on a white background.
        layer_on = '0; layer_en = '1; bg_rgb = 12'hFFF;
        run_frame(16, REQ_OUT, -1, '0, 0, s);
        check("s040_f0", s, 12'hFFF);
        check("s040_busy", fade_busy, 1);
        fade_seq = '{12'h777, 12'h333, 12'h111, 12'h000};
        for (int f = 0; f < 4; f++) begin
            run_frame(f == 1 ? 16 : -1, REQ_OUT, -1, '0, 0, s);
            check("s040_step", s, fade_seq[f]);
        end
        check("s040_blank_busy", fade_busy, 0);
        run_frame(5, REQ_OUT, -1, '0, 0, s);
        check("s040_blank_hold", s, 12'h000);

        // Fade back in from BLANK.
        run_frame(16, REQ_IN, -1, '0, 0, s);
        check("fade_in_f0", s, 12'h000);
        for (int f = 3; f >= 0; f--) begin
            run_frame(-1, 0, -1, '0, 0, s);
            check("fade_in_step", s, f == 0 ? 12'hFFF : fade_seq[f-1]);
        end
        check("fade_in_done_busy", fade_busy, 0);

        // Reversal at shift 2: both requests together start a fade-out.
        run_frame(16, REQ_BOTH, -1, '0, 0, s);
        check("s041_f0", s, 12'hFFF);
        run_frame(16, REQ_OUT, -1, '0, 0, s);
        check("s041_sh1", s, 12'h777);
        run_frame(16, REQ_IN, -1, '0, 0, s);
        check("s041_sh2", s, 12'h333);
        run_frame(-1, 0, -1, '0, 0, s);
        check("s041_back1", s, 12'h777);
        run_frame(-1, 0, -1, '0, 0, s);
        check("s041_back0", s, 12'hFFF);
        check("s041_normal_busy", fade_busy, 0);

        // Colour key over a blue background.
        layer_rgb = {12'h333, 12'hF00, 12'h0A0, 12'hF0F};
        layer_on = 4'b0001; bg_rgb = 12'h00F;
`ifdef DISPLAY_COMPOSITOR_TRANSPARENCY_EN
        exp_key = 12'h00F;
`else
        exp_key = 12'hF0F;
`endif
        run_frame(-1, 0, -1, '0, 0, s);
        check("s042_key", s, exp_key);

        // Reset in the middle of a fade.
        layer_on = '0; bg_rgb = 12'hFFF;
        run_frame(16, REQ_OUT, -1, '0, 0, s);
        for (int i = 0; i < 13; i++) cyc(1);
        check("s043_fading", fade_busy, 1);
        #2 hard_reset_n = 0;
        #1;
        check("s043_rst_rgb", rgb, 0);
        check("s043_rst_busy", fade_busy, 0);
        check("s043_rst_fc", frame_count, 0);
        model_reset();
        bg_rgb = 12'h5A3;
        @(negedge clk) hard_reset_n = 1;
        run_frame(-1, 0, -1, '0, 0, s);
        check("s043_unshifted", s, 12'h5A3);
        check("s043_fc_restart", frame_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
